// File: rtl/ex_mem_pipe_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : ex_mem_pipe_if                                                |
// | Description : Bundle between the EX stage and the EX/MEM pipeline register. |
// |               Carries the EX-stage instruction fields in, the registered    |
// |               EX/MEM fields and flags out, and the ID/EX source indices     |
// |               used for the EX/MEM forward selects.                          |
// |   master : EX/control side; drives instruction fields, stall/flush,         |
// |            src_a/src_b; receives out* fields, flags, fwd_a/fwd_b.           |
// |   slave  : the EX/MEM pipeline register itself.                             |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
interface ex_mem_pipe_if;
    // EX stage instruction
    logic        in_valid;
    logic [63:0] alu_result;
    logic [63:0] store_data;
    logic [4:0]  rd;
    logic        reg_wr;
    logic        mem_wr;
    logic        mem_rd;
    logic        ldurb;
    logic        set_flg;
    logic [3:0]  alu_flags;
    // pipeline control
    logic        stall;
    logic        flush;
    // ID/EX source registers for forwarding
    logic [4:0]  src_a;
    logic [4:0]  src_b;
    // EX/MEM registered outputs
    logic        outValid;
    logic        outreg_wr;
    logic        outmem_wr;
    logic        outmem_rd;
    logic        outldurb;
    logic [63:0] outAluResult;
    logic [63:0] outStoreData;
    logic [4:0]  outRd;
    logic [3:0]  flags;
    logic        fwd_a;
    logic        fwd_b;

    modport master (
        output in_valid, alu_result, store_data, rd, reg_wr, mem_wr, mem_rd,
               ldurb, set_flg, alu_flags, stall, flush, src_a, src_b,
        input  outValid, outreg_wr, outmem_wr, outmem_rd, outldurb,
               outAluResult, outStoreData, outRd, flags, fwd_a, fwd_b
    );

    modport slave (
        input  in_valid, alu_result, store_data, rd, reg_wr, mem_wr, mem_rd,
               ldurb, set_flg, alu_flags, stall, flush, src_a, src_b,
        output outValid, outreg_wr, outmem_wr, outmem_rd, outldurb,
               outAluResult, outStoreData, outRd, flags, fwd_a, fwd_b
    );
endinterface
`default_nettype wire

// File: rtl/ex_mem_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : ex_mem_pipe                                                   |
// | Description : EX/MEM pipeline register with the architectural NZVC flag     |
// |               register and EX/MEM -> EX forward-select generation.          |
// |               Per-edge priority: reset > flush > stall > load.              |
// | Ports       : clk   - rising-edge clock                                     |
// |               reset - synchronous active-high reset                         |
// |               bus   - ex_mem_pipe_if.slave (instruction in, EX/MEM out,     |
// |                       stall/flush, src_a/src_b, fwd_a/fwd_b)                |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
module ex_mem_pipe (
    input  wire           clk,
    input  wire           reset,
    ex_mem_pipe_if.slave  bus
);

    localparam logic [4:0] C_XZR = 5'd31;

    logic        r_valid;
    logic        r_reg_wr;
    logic        r_mem_wr;
    logic        r_mem_rd;
    logic        r_ldurb;
    logic [63:0] r_alu_result;
    logic [63:0] r_store_data;
    logic [4:0]  r_rd;
    logic [3:0]  r_flags;

    logic        w_load;
    logic        w_fwd_ok;

    assign w_load = !bus.flush && !bus.stall;

    // Pipeline register. Control bits are qualified by in_valid so an
    // invalid slot can never write registers or memory; data is captured
    // regardless since it is harmless without the controls.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid      <= 1'b0;
            r_reg_wr     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_ldurb      <= 1'b0;
            r_alu_result <= 64'd0;
            r_store_data <= 64'd0;
            r_rd         <= 5'd0;
        end else if (bus.flush) begin
            // flush also wins over stall: the held instruction is dropped
            r_valid      <= 1'b0;
            r_reg_wr     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_ldurb      <= 1'b0;
            r_alu_result <= 64'd0;
            r_store_data <= 64'd0;
            r_rd         <= 5'd0;
        end else if (!bus.stall) begin
            r_valid      <= bus.in_valid;
            r_reg_wr     <= bus.in_valid & bus.reg_wr;
            r_mem_wr     <= bus.in_valid & bus.mem_wr;
            r_mem_rd     <= bus.in_valid & bus.mem_rd;
            r_ldurb      <= bus.in_valid & bus.ldurb;
            r_alu_result <= bus.alu_result;
            r_store_data <= bus.store_data;
            r_rd         <= bus.rd;
        end
    end

    // Architectural flags: only a real, loading, flag-setting instruction
    // commits; bubbles, stalls and flushes leave them alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else if (w_load && bus.in_valid && bus.set_flg) begin
            r_flags <= bus.alu_flags;
        end
    end

    // XZR is never a real producer. Reset gates the selects directly so they
    // are low during reset even before the first reset edge clears state.
    assign w_fwd_ok  = !reset && r_valid && r_reg_wr && (r_rd != C_XZR);
    assign bus.fwd_a = w_fwd_ok && (r_rd == bus.src_a);
    assign bus.fwd_b = w_fwd_ok && (r_rd == bus.src_b);

    assign bus.outValid     = r_valid;
    assign bus.outreg_wr    = r_reg_wr;
    assign bus.outmem_wr    = r_mem_wr;
    assign bus.outmem_rd    = r_mem_rd;
    assign bus.outldurb     = r_ldurb;
    assign bus.outAluResult = r_alu_result;
    assign bus.outStoreData = r_store_data;
    assign bus.outRd        = r_rd;
    assign bus.flags        = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_ex_mem_pipe                                                |
// | Description : Self-checking bench for ex_mem_pipe. A behavioural model of   |
// |               the EX/MEM slot is compared against the DUT every cycle, and  |
// |               directed vectors pin hand-computed values.                    |
// | Revision    : 1.0  initial release                                          |
// +-----------------------------------------------------------------------------+
module tb_ex_mem_pipe;

    logic clk;
    logic reset;
    ex_mem_pipe_if bus ();

    ex_mem_pipe dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: the slot contents as a record of what the last accepted
    // instruction was, plus the committed flags.
    typedef struct {
        bit          valid;
        bit          reg_wr, mem_wr, mem_rd, ldurb;
        logic [63:0] alu, sd;
        logic [4:0]  rd;
    } slot_t;

    slot_t       m_slot;
    logic [3:0]  m_flags;

    function automatic slot_t empty_slot();
        slot_t s;
        s.valid = 0; s.reg_wr = 0; s.mem_wr = 0; s.mem_rd = 0; s.ldurb = 0;
        s.alu = '0; s.sd = '0; s.rd = '0;
        return s;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_slot  <= empty_slot();
            m_flags <= 4'b0000;
        end else if (bus.flush) begin
            m_slot  <= empty_slot();
        end else if (!bus.stall) begin
            slot_t s;
            s = empty_slot();
            s.alu = bus.alu_result;
            s.sd  = bus.store_data;
            s.rd  = bus.rd;
            if (bus.in_valid) begin
                s.valid  = 1;
                s.reg_wr = bus.reg_wr;
                s.mem_wr = bus.mem_wr;
                s.mem_rd = bus.mem_rd;
                s.ldurb  = bus.ldurb;
                if (bus.set_flg) m_flags <= bus.alu_flags;
            end
            m_slot <= s;
        end
    end

    function automatic bit model_fwd(input logic [4:0] src);
        return !reset && m_slot.valid && m_slot.reg_wr && m_slot.rd != 5'd31 && m_slot.rd == src;
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc outValid",     bus.outValid,     m_slot.valid);
            chk("cyc outreg_wr",    bus.outreg_wr,    m_slot.reg_wr);
            chk("cyc outmem_wr",    bus.outmem_wr,    m_slot.mem_wr);
            chk("cyc outmem_rd",    bus.outmem_rd,    m_slot.mem_rd);
            chk("cyc outldurb",     bus.outldurb,     m_slot.ldurb);
            chk("cyc outAluResult", bus.outAluResult, m_slot.alu);
            chk("cyc outStoreData", bus.outStoreData, m_slot.sd);
            chk("cyc outRd",        bus.outRd,        m_slot.rd);
            chk("cyc flags",        bus.flags,        m_flags);
            chk("cyc fwd_a",        bus.fwd_a,        model_fwd(bus.src_a));
            chk("cyc fwd_b",        bus.fwd_b,        model_fwd(bus.src_b));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.in_valid = 0; bus.alu_result = '0; bus.store_data = '0; bus.rd = '0;
        bus.reg_wr = 0; bus.mem_wr = 0; bus.mem_rd = 0; bus.ldurb = 0;
        bus.set_flg = 0; bus.alu_flags = '0; bus.stall = 0; bus.flush = 0;
    endtask

    initial begin
        clear_in();
        bus.src_a = 5'd0;
        bus.src_b = 5'd0;
        reset = 1'b1;
        cyc();
        cmp_en = 1'b1;
        chk("reset outValid", bus.outValid, 0);
        chk("reset flags",    bus.flags,    4'b0000);
        reset = 1'b0;

        // ADDS: one-cycle latency, flags committed
        clear_in();
        bus.in_valid = 1; bus.alu_result = 64'h10; bus.rd = 5'd3;
        bus.reg_wr = 1; bus.set_flg = 1; bus.alu_flags = 4'b0100;
        cyc();
        chk("adds outAluResult", bus.outAluResult, 64'h10);
        chk("adds outRd",        bus.outRd,        3);
        chk("adds outreg_wr",    bus.outreg_wr,    1);
        chk("adds outValid",     bus.outValid,     1);
        chk("adds flags",        bus.flags,        4'b0100);

        // forwarding from rd=3, same-cycle on src change
        bus.stall = 1;
        bus.src_a = 5'd3; bus.src_b = 5'd4;
        #1;
        chk("fwd rd3 fwd_a", bus.fwd_a, 1);
        chk("fwd rd3 fwd_b", bus.fwd_b, 0);
        bus.src_b = 5'd3;
        #1;
        chk("fwd rd3 fwd_b match", bus.fwd_b, 1);

        // rd=31 never forwards
        clear_in();
        bus.in_valid = 1; bus.rd = 5'd31; bus.reg_wr = 1; bus.alu_result = 64'h20;
        bus.src_a = 5'd31; bus.src_b = 5'd31;
        cyc();
        chk("xzr fwd_a", bus.fwd_a, 0);
        chk("xzr fwd_b", bus.fwd_b, 0);

        // STUR then stall 3 cycles with changing inputs
        clear_in();
        bus.in_valid = 1; bus.mem_wr = 1; bus.store_data = 64'hDEAD;
        bus.alu_result = 64'h100; bus.rd = 5'd9;
        cyc();
        for (int i = 0; i < 3; i++) begin
            bus.stall = 1; bus.in_valid = 1; bus.set_flg = 1; bus.alu_flags = 4'b1111;
            bus.store_data = 64'h1234 + 64'(i); bus.mem_wr = 0; bus.reg_wr = 1;
            bus.rd = 5'(i + 1);
            cyc();
            chk("stall outStoreData", bus.outStoreData, 64'hDEAD);
            chk("stall outmem_wr",    bus.outmem_wr,    1);
            chk("stall flags",        bus.flags,        4'b0100);
        end

        // SUBS with flush and stall together: bubble, flags untouched
        clear_in();
        bus.in_valid = 1; bus.set_flg = 1; bus.alu_flags = 4'b1010; bus.reg_wr = 1;
        bus.mem_wr = 1; bus.rd = 5'd7; bus.alu_result = 64'h77; bus.flush = 1; bus.stall = 1;
        cyc();
        chk("flush outValid",     bus.outValid,     0);
        chk("flush outmem_wr",    bus.outmem_wr,    0);
        chk("flush outreg_wr",    bus.outreg_wr,    0);
        chk("flush outRd",        bus.outRd,        0);
        chk("flush outStoreData", bus.outStoreData, 0);
        chk("flush flags",        bus.flags,        4'b0100);

        // invalid slot with controls set: controls squashed, data captured
        clear_in();
        bus.reg_wr = 1; bus.mem_wr = 1; bus.set_flg = 1; bus.alu_flags = 4'b0001;
        bus.rd = 5'd5; bus.alu_result = 64'h55; bus.src_a = 5'd5;
        cyc();
        chk("inval outreg_wr",    bus.outreg_wr,    0);
        chk("inval outmem_wr",    bus.outmem_wr,    0);
        chk("inval flags",        bus.flags,        4'b0100);
        chk("inval fwd_a",        bus.fwd_a,        0);
        chk("inval outAluResult", bus.outAluResult, 64'h55);

        // mem_wr and mem_rd together pass through unchanged
        clear_in();
        bus.in_valid = 1; bus.mem_wr = 1; bus.mem_rd = 1; bus.rd = 5'd2;
        cyc();
        chk("both outmem_wr", bus.outmem_wr, 1);
        chk("both outmem_rd", bus.outmem_rd, 1);

        // LDURB, then reset while stalled
        clear_in();
        bus.in_valid = 1; bus.mem_rd = 1; bus.ldurb = 1; bus.reg_wr = 1; bus.rd = 5'd3;
        bus.set_flg = 1; bus.alu_flags = 4'b0011; bus.alu_result = 64'h40;
        cyc();
        chk("ldurb flags",    bus.flags,    4'b0011);
        chk("ldurb outldurb", bus.outldurb, 1);
        bus.stall = 1; bus.src_a = 5'd3;
        #1;
        chk("ldurb fwd_a", bus.fwd_a, 1);
        reset = 1;
        #1;
        chk("reset fwd_a low", bus.fwd_a, 0);
        cyc();
        chk("rst outValid",     bus.outValid,     0);
        chk("rst outldurb",     bus.outldurb,     0);
        chk("rst outAluResult", bus.outAluResult, 0);
        chk("rst outRd",        bus.outRd,        0);
        chk("rst flags",        bus.flags,        4'b0000);
        reset = 0;

        // first load after reset
        clear_in();
        bus.in_valid = 1; bus.alu_result = 64'hABCD; bus.rd = 5'd12; bus.reg_wr = 1;
        bus.set_flg = 1; bus.alu_flags = 4'b1000; bus.src_b = 5'd12;
        cyc();
        chk("post outAluResult", bus.outAluResult, 64'hABCD);
        chk("post flags",        bus.flags,        4'b1000);
        chk("post fwd_b",        bus.fwd_b,        1);

        clear_in();
        cyc();
        cyc();
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_mem_pipe.md
EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

Interface
REQ-001 SHALL: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL: reset  input  1  synchronous, active-high; one clock; sampled on rising edge of clk.
REQ-003 SHALL: in_valid  input  1  EX stage holds a real instruction.
REQ-004 SHALL: alu_result  input  64  EX ALU output (address for loads/stores).
REQ-005 SHALL: store_data  input  64  register data to be written to memory (STUR/STURB).
REQ-006 SHALL: rd  input  5  destination register index.
REQ-007 SHALL: reg_wr, mem_wr, mem_rd, ldurb  input  1 each  control carried from ID/EX.
REQ-008 SHALL: set_flg  input  1  EX instruction updates condition flags.
REQ-009 SHALL: alu_flags  input  4  {N,Z,V,C} from ALU this cycle.
REQ-010 SHALL: stall  input  1  hold all registered state.
REQ-011 SHALL: flush  input  1  replace the incoming instruction with a bubble.
REQ-012 SHALL: src_a, src_b  input  5 each  source register indices of the instruction currently in ID/EX.
REQ-013 SHALL: outValid, outreg_wr, outmem_wr, outmem_rd, outldurb  output  1 each  registered copies.
REQ-014 SHALL: outAluResult, outStoreData  output  64 each; outRd  output  5  registered copies.
REQ-015 SHALL: flags  output  4  architectural {N,Z,V,C} register.
REQ-016 SHALL: fwd_a, fwd_b  output  1 each  EX/MEM forward select for src_a/src_b.

Function
REQ-017 SHALL: per rising edge, priority reset > flush > stall > load.
REQ-018 SHALL: load: every out* field takes its input on the next edge; latency exactly 1 cycle.
REQ-019 SHALL: load with in_valid=0: outValid=0 and outreg_wr, outmem_wr, outmem_rd, outldurb forced 0; data fields still captured.
REQ-020 SHALL: stall (flush=0): all outputs and flags hold their values; no flag update.
REQ-021 SHALL: flush: outValid, outreg_wr, outmem_wr, outmem_rd, outldurb, outAluResult, outStoreData, outRd all go to 0; flags unchanged.
REQ-022 SHALL: flags load alu_flags on an edge only when load occurs, in_valid=1 and set_flg=1; otherwise hold.
REQ-023 SHALL: flush and stall asserted together produce a bubble (flush wins); the instruction is not retained.
REQ-024 SHALL: fwd_a = outValid & outreg_wr & (outRd != 31) & (outRd == src_a); fwd_b likewise with src_b; combinational from registered state.
REQ-025 SHALL: outRd = 31 (XZR) never forwards, regardless of outreg_wr.
REQ-026 SHALL: mem_wr and mem_rd both 1 on input is passed through unmodified; no arbitration in this block.
REQ-027 SHALL: no combinational path from data inputs (alu_result, store_data, rd, control, alu_flags) to any output; only src_a/src_b feed fwd_a/fwd_b combinationally.

Reset
REQ-028 SHALL: reset edge sets every output register and flags to 0 (outValid=0, flags=4'b0000).
REQ-029 SHALL: reset overrides stall and flush in the same cycle.
REQ-030 SHALL: reset asserted mid-stream discards the held instruction; first load after reset deassertion behaves per REQ-018.
REQ-031 SHALL: while reset=1, fwd_a=fwd_b=0.

Verification
REQ-032 SHALL: reset 1 cycle, then ADDS valid, alu_result=64'h10, rd=3, reg_wr=1, set_flg=1, alu_flags=4'b0100 -> next edge outAluResult=64'h10, outRd=3, outreg_wr=1, outValid=1, flags=4'b0100.
REQ-033 SHALL: outRd=3, outreg_wr=1 registered; drive src_a=3, src_b=4 -> fwd_a=1, fwd_b=0 same cycle; repeat with rd=31 -> fwd_a=0.
REQ-034 SHALL: STUR valid mem_wr=1, store_data=64'hDEAD, then stall=1 for 3 cycles with new inputs changing -> outputs hold 64'hDEAD, mem_wr=1 throughout; flags unchanged even with set_flg=1.
REQ-035 SHALL: SUBS valid set_flg=1 with flush=1 and stall=1 -> next edge outValid=0, outmem_wr=0, outreg_wr=0, outRd=0, flags unchanged.
REQ-036 SHALL: in_valid=0 with reg_wr=1, mem_wr=1, set_flg=1 -> outreg_wr=0, outmem_wr=0, flags unchanged, fwd_a=0.
REQ-037 SHALL: reset asserted while stall=1 holding a valid LDURB -> next edge all outputs 0, outldurb=0, flags=0.
